// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array feed path: streamer FSM encoding,
// band geometry and lane packing helpers.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

    // Number of overlapping row bands a LANES-tall window yields.
    function automatic int calc_bands(input int img_rows, input int lanes);
        return img_rows - lanes + 1;
    endfunction

    function automatic int calc_stream_beats(input int img_rows, input int img_cols,
                                             input int lanes);
        return calc_bands(img_rows, lanes) * img_cols;
    endfunction

    // Bit offset of lane k inside a packed x_ins word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Counter width that is never zero, even for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_regfile.sv
// Feature-map buffer: one write port, LANES combinational read ports that
// fetch one column of a row band in a single cycle.
module pixel_regfile
    import systolic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IMG_ROWS   = 8,
    parameter int IMG_COLS   = 8,
    parameter int LANES      = 5,
    parameter int ADDR_WIDTH = 6,
    parameter int BAND_W     = 2,
    parameter int COL_W      = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_WIDTH-1:0]    waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [BAND_W-1:0]        band,
    input  logic [COL_W-1:0]         col,
    output logic [LANES*WIDTH-1:0]   rd_lanes
);

    localparam int DEPTH = IMG_ROWS * IMG_COLS;
    localparam int IDX_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;

    // Widened compare so an address equal to DEPTH is caught even when DEPTH is 2**ADDR_WIDTH.
    assign in_range = {1'b0, waddr} < (ADDR_WIDTH + 1)'(DEPTH);

    // NOTE: the pixel array has no reset on purpose; resetting 64 words of
    // storage costs a reset tree for data that is always rewritten before use.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] rd_idx;
        assign rd_idx = IDX_W'((int'(band) + k) * IMG_COLS + int'(col));
        assign rd_lanes[lane_lsb(k, WIDTH) +: WIDTH] = mem[rd_idx];
    end

endmodule

// File: rtl/conv_band_streamer.sv
// Streams overlapping row bands of a buffered int8 feature map onto the
// systolic array x_ins bus, then drains the array with zero beats.
module conv_band_streamer
    import systolic_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int IMG_ROWS    = 8,
    parameter int IMG_COLS    = 8,
    parameter int LANES       = 5,
    parameter int FLUSH_BEATS = 32,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_we,
    input  logic [ADDR_WIDTH-1:0]  pix_addr,
    input  logic [WIDTH-1:0]       pix_data,
    input  logic                   start,
    input  logic                   hold,
    output logic [LANES*WIDTH-1:0] x_ins,
    output logic                   x_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int BANDS   = calc_bands(IMG_ROWS, LANES);
    localparam int BAND_W  = cnt_width(BANDS);
    localparam int COL_W   = cnt_width(IMG_COLS);
    localparam int FLUSH_W = cnt_width(FLUSH_BEATS + 1);

    stream_state_t          state;
    stream_state_t          next_state;
    logic [BAND_W-1:0]      band;
    logic [COL_W-1:0]       col;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic [LANES*WIDTH-1:0] rd_lanes;
    logic                   last_col;
    logic                   last_band;
    logic                   flush_end;

    assign last_col  = (col == COL_W'(IMG_COLS - 1));
    assign last_band = (band == BAND_W'(BANDS - 1));
    assign flush_end = (flush_cnt == FLUSH_W'(FLUSH_BEATS));

    pixel_regfile #(
        .WIDTH      (WIDTH),
        .IMG_ROWS   (IMG_ROWS),
        .IMG_COLS   (IMG_COLS),
        .LANES      (LANES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BAND_W     (BAND_W),
        .COL_W      (COL_W)
    ) u_regfile (
        .clk      (clk),
        .we       (pix_we && (state == ST_IDLE)),
        .waddr    (pix_addr),
        .wdata    (pix_data),
        .band     (band),
        .col      (col),
        .rd_lanes (rd_lanes)
    );

    // NOTE: every flop is written with <= so all registers sample the same
    // pre-edge values; a blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_STREAM;
            ST_STREAM: if (!hold && last_col && last_band) next_state = ST_FLUSH;
            ST_FLUSH:  if (!hold && flush_end) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Counters and output register; a held beat keeps x_ins and only drops x_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band      <= '0;
            col       <= '0;
            flush_cnt <= '0;
            x_ins     <= '0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_DONE);
            case (state)
                ST_STREAM: begin
                    x_valid <= !hold;
                    if (!hold) begin
                        x_ins <= rd_lanes;
                        if (last_col) begin
                            col  <= '0;
                            band <= last_band ? '0 : band + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    x_valid <= !hold && !flush_end;
                    if (!hold) begin
                        x_ins     <= '0;
                        flush_cnt <= flush_end ? '0 : flush_cnt + 1'b1;
                    end
                end
                default: begin
                    x_ins   <= '0;
                    x_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_band_streamer.sv
// Self-checking bench for conv_band_streamer: directed scenarios on the reference
// image plus randomized images and stalls, checked against a row/column model.
module tb_conv_band_streamer;

    localparam int WIDTH        = 8;
    localparam int IMG_ROWS     = 8;
    localparam int IMG_COLS     = 8;
    localparam int LANES        = 5;
    localparam int FLUSH_BEATS  = 32;
    localparam int ADDR_WIDTH   = 7;
    localparam int STREAM_BEATS = (IMG_ROWS - LANES + 1) * IMG_COLS;
    localparam int TOTAL_BEATS  = STREAM_BEATS + FLUSH_BEATS;
    localparam int LW           = LANES * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  pix_we;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [WIDTH-1:0]      pix_data;
    logic                  start;
    logic                  hold;
    logic [LW-1:0]         x_ins;
    logic                  x_valid;
    logic                  busy;
    logic                  done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] img [IMG_ROWS][IMG_COLS];

    int test_img [IMG_ROWS][IMG_COLS] = '{
        '{0, 1, 4, 2, 2, 0, 0, 3},
        '{7, 0, 0, 2, 3, 3, 1, 2},
        '{4, 10, 0, 0, 0, 1, 1, 2},
        '{2, 5, 6, 6, 3, 6, 0, 0},
        '{11, 0, 1, 12, 10, 3, 6, 0},
        '{0, 10, 0, 1, 2, 11, 3, 0},
        '{4, 0, 2, 0, 1, 0, 2, 3},
        '{3, 4, 1, 1, 1, 4, 0, 2}
    };

    conv_band_streamer #(
        .WIDTH       (WIDTH),
        .IMG_ROWS    (IMG_ROWS),
        .IMG_COLS    (IMG_COLS),
        .LANES       (LANES),
        .FLUSH_BEATS (FLUSH_BEATS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_we   (pix_we),
        .pix_addr (pix_addr),
        .pix_data (pix_data),
        .start    (start),
        .hold     (hold),
        .x_ins    (x_ins),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Beat n of a run: stream beats read column (n mod cols) of the band starting at row n/cols.
    function automatic logic [LW-1:0] exp_beat(input int n);
        logic [LW-1:0] w;
        w = '0;
        if (n < STREAM_BEATS) begin
            for (int k = 0; k < LANES; k++) begin
                w[k*WIDTH +: WIDTH] = img[n / IMG_COLS + k][n % IMG_COLS];
            end
        end
        return w;
    endfunction

    function automatic logic [LW-1:0] pack5(input int l4, input int l3, input int l2,
                                            input int l1, input int l0);
        return {8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic write_pix(input int addr, input logic [WIDTH-1:0] data);
        pix_we   = 1'b1;
        pix_addr = ADDR_WIDTH'(addr);
        pix_data = data;
        tick();
        pix_we = 1'b0;
        if (addr < IMG_ROWS * IMG_COLS) img[addr / IMG_COLS][addr % IMG_COLS] = data;
    endtask

    task automatic check_idle_outputs(input string name);
        check($sformatf("%s x_ins_zero", name), 64'(x_ins), 64'd0);
        check($sformatf("%s x_valid_low", name), 64'(x_valid), 64'd0);
        check($sformatf("%s busy_low", name), 64'(busy), 64'd0);
        check($sformatf("%s done_low", name), 64'(done), 64'd0);
    endtask

    // mode 0: no stall, 1: three-cycle stall after beat hold_beat, 2: random stalls.
    task automatic run_check(input string name, input int mode, input int hold_beat,
                             input int poke_beat, input int stop_beat, input bit spec_img);
        int            beat;
        int            cyc;
        int            holds;
        int            hold_rem;
        bit            hold_q;
        bit            poked;
        logic [LW-1:0] last_w;
        beat = 0; cyc = 0; holds = 0; hold_rem = 0; hold_q = 0; poked = 0;
        last_w = '0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        pix_we = 1'b0;
        check($sformatf("%s busy_rise", name), 64'(busy), 64'd1);
        check($sformatf("%s no_beat_yet", name), 64'(x_valid), 64'd0);
        while (beat < TOTAL_BEATS && cyc < 400) begin
            tick();
            cyc++;
            start  = 1'b0;
            pix_we = 1'b0;
            if (hold_q) begin
                holds++;
                check($sformatf("%s stall_valid b%0d", name, beat), 64'(x_valid), 64'd0);
                check($sformatf("%s stall_data b%0d", name, beat), 64'(x_ins), 64'(last_w));
                if (spec_img && beat == 11)
                    check($sformatf("%s stall_spec", name), 64'(x_ins), 64'(pack5(0, 1, 6, 0, 0)));
            end else begin
                last_w = exp_beat(beat);
                check($sformatf("%s valid b%0d", name, beat), 64'(x_valid), 64'd1);
                check($sformatf("%s data b%0d", name, beat), 64'(x_ins), 64'(last_w));
                if (spec_img) begin
                    case (beat)
                        0:  check($sformatf("%s spec_b0", name), 64'(x_ins), 64'(pack5(11, 2, 4, 7, 0)));
                        1:  check($sformatf("%s spec_b1", name), 64'(x_ins), 64'(pack5(0, 5, 10, 0, 1)));
                        8:  check($sformatf("%s spec_b8", name), 64'(x_ins), 64'(pack5(0, 11, 2, 4, 7)));
                        31: check($sformatf("%s spec_b31", name), 64'(x_ins), 64'(pack5(2, 3, 0, 0, 0)));
                        default: ;
                    endcase
                end
                beat++;
            end
            if (stop_beat >= 0 && beat == stop_beat + 1) begin
                hold = 1'b0;
                return;
            end
            if (mode == 1 && !hold_q && holds == 0 && beat == hold_beat + 1) hold_rem = 3;
            if (mode == 2) begin
                hold = (beat >= 1 && beat < TOTAL_BEATS && $urandom_range(0, 3) == 0);
            end else begin
                hold = (hold_rem > 0);
                if (hold_rem > 0) hold_rem--;
            end
            if (beat >= TOTAL_BEATS) hold = 1'b0;
            hold_q = hold;
            if (poke_beat >= 0 && !poked && beat == poke_beat + 1) begin
                poked    = 1;
                start    = 1'b1;
                pix_we   = 1'b1;
                pix_addr = '0;
                pix_data = 8'd99;
            end
        end
        check($sformatf("%s all_beats_seen", name), 64'(beat), 64'(TOTAL_BEATS));
        hold = 1'b0;
        tick();
        cyc++;
        check($sformatf("%s done_pulse", name), 64'(done), 64'd1);
        check($sformatf("%s done_time", name), 64'(cyc), 64'(TOTAL_BEATS + 1 + holds));
        check($sformatf("%s done_busy", name), 64'(busy), 64'd1);
        check($sformatf("%s done_novalid", name), 64'(x_valid), 64'd0);
        tick();
        check($sformatf("%s done_drop", name), 64'(done), 64'd0);
        check($sformatf("%s busy_drop", name), 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        pix_we   = 1'b0;
        pix_addr = '0;
        pix_data = '0;
        start    = 1'b0;
        hold     = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < IMG_ROWS; r++)
            for (int c = 0; c < IMG_COLS; c++)
                write_pix(r * IMG_COLS + c, 8'(test_img[r][c]));

        run_check("s1", 0, -1, -1, -1, 1'b1);
        run_check("s3", 1, 10, -1, -1, 1'b1);
        run_check("s4", 0, -1, 5, -1, 1'b1);
        run_check("s4b", 0, -1, -1, -1, 1'b1);

        run_check("s5", 0, -1, -1, 20, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("s5 async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("s5 released");
        run_check("s5b", 0, -1, -1, -1, 1'b1);

        write_pix(64, 8'd77);
        run_check("s6", 0, -1, -1, -1, 1'b1);

        for (int r = 0; r < IMG_ROWS; r++)
            for (int c = 0; c < IMG_COLS; c++)
                write_pix(r * IMG_COLS + c, 8'($urandom));
        run_check("rnd1", 2, -1, -1, -1, 1'b0);

        pix_we   = 1'b1;
        pix_addr = '0;
        pix_data = 8'd55;
        img[0][0] = 8'd55;
        run_check("start_we", 0, -1, -1, -1, 1'b0);
        run_check("rnd2", 2, -1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
